// File: rtl/systolic_ctrl_pkg.sv
// Shared constants for the systolic array sequencer: FSM state encodings and
// default array geometry.
package systolic_pkg;

  localparam int N_DEF   = 4;
  localparam int K_W_DEF = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/systolic_ctrl_skew_shreg.sv
// Per-row enable skew: bit 0 is the registered fire, each higher bit is one
// more cycle of delay. Also usable for the column-side operand skew.
module skew_shreg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fire,
  output logic [N-1:0] skew_en
);

  logic [N-1:0] skew_d, skew_q;

  always_comb begin
    skew_d = {skew_q[N-2:0], fire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) skew_q <= '0;
    else     skew_q <= skew_d;
  end

  assign skew_en = skew_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for an N x N systolic MAC array: load K beats, flush the
// wavefront, drain N rows. SYSTOLIC_CTRL_PERF_EN adds the perf_stall counter.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int K_W       = K_W_DEF,
  parameter int FLUSH_CYC = 2 * N - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [K_W-1:0]       k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 acc_clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N-1:0]         skew_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_row
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [15:0]          perf_stall
`endif
);

  localparam int RW = $clog2(N);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(N - 1);

  logic [2:0]     state_d, state_q;
  logic [K_W-1:0] k_len_d, k_len_q;
  logic [K_W-1:0] beat_d, beat_q;
  logic [FW-1:0]  flush_d, flush_q;
  logic [RW-1:0]  row_d, row_q;
  logic           zero_d, zero_q;
  logic           acc_clr_d, acc_clr_q;
  logic           fire;

  assign fire = in_valid & (state_q == ST_LOAD);

  always_comb begin
    state_d   = state_q;
    k_len_d   = k_len_q;
    beat_d    = beat_q;
    flush_d   = flush_q;
    row_d     = row_q;
    zero_d    = zero_q;
    acc_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (k_len == '0) begin
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            zero_d    = 1'b0;
            k_len_d   = k_len;
            beat_d    = '0;
            acc_clr_d = 1'b1;
            state_d   = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (fire) begin
          if (beat_q == k_len_q - K_W'(1)) begin
            beat_d  = '0;
            flush_d = FLUSH_LOAD;
            state_d = ST_FLUSH;
          end else begin
            beat_d = beat_q + K_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == '0) begin
          row_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          flush_d = flush_q - FW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = ST_DONE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_len_q   <= '0;
      beat_q    <= '0;
      flush_q   <= '0;
      row_q     <= '0;
      zero_q    <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_len_q   <= k_len_d;
      beat_q    <= beat_d;
      flush_q   <= flush_d;
      row_q     <= row_d;
      zero_q    <= zero_d;
      acc_clr_q <= acc_clr_d;
    end
  end

  skew_shreg #(.N(N)) u_skew (
    .clk     (clk),
    .rst     (reset),
    .fire    (fire),
    .skew_en (skew_en)
  );

  assign busy      = (state_q == ST_LOAD) | (state_q == ST_FLUSH) | (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) & zero_q;
  assign acc_clr   = acc_clr_q;
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_row   = row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0] perf_d, perf_q;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == ST_IDLE) && start) begin
      perf_d = '0;
    end else if ((((state_q == ST_LOAD) && !in_valid) ||
                  ((state_q == ST_DRAIN) && !out_ready)) && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_stall = perf_q;
`endif

endmodule
